dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Memory-access controller between the CPU load/store path and the 8-bit data memory DM. It accepts byte or 16-bit word load/store requests over a valid/ready handshake and sequences one or two DM accesses. Word data is little-endian: the low byte is at `addr` and the high byte at `addr+1`. Each request returns exactly one single-cycle response.

## Interface
Parameters:
- `AW`, 8: DM address width.
- `DW`, 8: DM data width; the word width is 2*DW.

Ports:
- `clk`, in, 1: the only clock; all registers update on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller can accept a request; equals `state==IDLE`.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_word`, in, 1: 1 = 16-bit access, 0 = byte access.
- `req_addr`, in, AW: base byte address.
- `req_wdata`, in, 2*DW: store data; only bits [7:0] are used for a byte store.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_rdata`, out, 2*DW: load data. Byte loads are zero-extended; stores return 0.
- `rsp_err`, out, 1: request rejected (only when `DMCTRL_ALIGN_CHECK_EN` is defined).
- `dm_address`, out, AW: drives DM `address`.
- `dm_WriteD`, out, DW: drives DM `WriteD`.
- `dm_MemRead`, out, 1: drives DM `MemRead`.
- `dm_MemWrite`, out, 1: drives DM `MemWrite`.
- `dm_ReadD`, in, DW: DM `ReadD`; combinational from `address` while `MemRead` is high.

## Operation
- State machine states: IDLE, LO, HI, RESP. The state register is 2 bits.
- Request registers: `a_addr`, `a_we`, `a_word`, `a_wdata`, `rdata_q`, `err_q`.
- IDLE:
  - `req_ready=1`; all `dm_*` outputs are 0.
  - On `req_valid`, latch the request, clear `rdata_q`, and go to LO.
  - If the alignment error applies (see Configuration), set `err_q` and go straight to RESP.
- LO:
  - `dm_address=a_addr`.
  - Store: `dm_MemWrite=1`, `dm_WriteD=a_wdata[7:0]`.
  - Load: `dm_MemRead=1`; at the clock edge `rdata_q[7:0]<=dm_ReadD`.
  - Next state is HI if `a_word`, otherwise RESP.
- HI:
  - `dm_address=a_addr+1` modulo 2^AW, so 0xFF wraps to 0x00.
  - Store writes `a_wdata[15:8]`; load captures into `rdata_q[15:8]`. Next state is RESP.
- RESP:
  - `rsp_valid=1`, `rsp_rdata=rdata_q`, `rsp_err=err_q`; all `dm_*` outputs are 0.
  - `req_ready=0`. Next state is IDLE.
- `rsp_rdata` and `rsp_err` hold their values until the next RESP.
- Controller is strictly in-order with one request outstanding. It never drives DM `Reset`.

## Timing
- A request is accepted at rising edge E0 where `req_valid && req_ready`.
- Byte access:
  - LO is the cycle after E0; the DM write commits, or the read is captured, at E1.
  - `rsp_valid` is high during the cycle after E1.
  - Accept-to-response latency is 2 cycles; throughput is 1 request per 3 cycles.
- Word access:
  - HI is the cycle after E1; the second byte commits at E2.
  - `rsp_valid` is high after E2; latency is 3 cycles, throughput 1 per 4 cycles.
- Alignment error: RESP is the cycle after E0, and no `dm_*` strobe is asserted.
- `req_ready` is low in LO, HI and RESP; a request held during those states is accepted on the first IDLE edge.
- Request inputs are sampled only at E0. Later changes to them have no effect.
- Reset values:
  - State is IDLE; all request registers are 0.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, all `dm_*=0`, `req_ready=1`.
  - No request is accepted while `Reset` is high.
- Reset mid-operation:
  - The FSM aborts immediately (asynchronously) and the strobes drop.
  - No response is issued.
  - A word store aborted in HI leaves the low byte written and the high byte unwritten.

## Configuration
- `DMCTRL_ALIGN_CHECK_EN` defined:
  - A word request with `req_addr[0]=1` is rejected.
  - It produces `rsp_err=1` and `rsp_rdata=0`, with no DM access.
- Not defined:
  - `rsp_err` is tied to 0.
  - Odd word addresses proceed normally, including the 0xFF→0x00 wrap.

## Test plan
- Byte store to 0x07 with data 0x16 after reset:
  - the cycle after acceptance shows `dm_address=0x07`, `dm_WriteD=0x16`, `dm_MemWrite=1` for exactly one cycle;
  - `rsp_valid` pulses 2 cycles after acceptance with `rsp_err=0`.
- Byte load from 0x07 → `dm_MemRead=1` for one cycle, then `rsp_rdata=0x0016`.
- Word store of 0xA55A to 0x10:
  - DM[0x10]=0x5A and DM[0x11]=0xA5;
  - a following word load from 0x10 returns 0xA55A with 3-cycle latency.
- Word store of 0x1234 to 0xFF, macro undefined → DM[0xFF]=0x34, DM[0x00]=0x12.
- Word load from 0x0F with `DMCTRL_ALIGN_CHECK_EN` defined:
  - `rsp_valid` the cycle after acceptance with `rsp_err=1`, `rsp_rdata=0`;
  - no `dm_MemRead` or `dm_MemWrite` pulse.
- Back-to-back requests and reset abort:
  - two requests with `req_valid` held high → the second is accepted on the edge after RESP, and `req_ready` is low for 2 or 3 cycles;
  - `Reset` asserted during HI of a word store to 0x20 → strobes drop the same cycle, no `rsp_valid`, DM[0x20] written and DM[0x21] unchanged.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - byte/word load-store sequencer for an 8-bit data memory (optional DMCTRL_ALIGN_CHECK_EN)
module dm_access_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic            req_word,
  input  logic [AW-1:0]   req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [2*DW-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   dm_address,
  output logic [DW-1:0]   dm_WriteD,
  output logic            dm_MemRead,
  output logic            dm_MemWrite,
  input  logic [DW-1:0]   dm_ReadD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     a_addr_q, a_addr_d;
  logic              a_we_q, a_we_d;
  logic              a_word_q, a_word_d;
  logic [2*DW-1:0]   a_wdata_q, a_wdata_d;
  logic [2*DW-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2*DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [AW-1:0]     dm_address_q, dm_address_d;
  logic [DW-1:0]     dm_WriteD_q, dm_WriteD_d;
  logic              dm_MemRead_q, dm_MemRead_d;
  logic              dm_MemWrite_q, dm_MemWrite_d;

  logic              align_err;

`ifdef DMCTRL_ALIGN_CHECK_EN
  // Odd-addressed word requests are refused before touching memory.
  assign align_err = req_word & req_addr[0];
`else
  assign align_err = 1'b0;
`endif

  // Next-state and request-register update; read bytes are merged into rdata as they arrive.
  always_comb begin
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    a_we_d    = a_we_q;
    a_word_d  = a_word_q;
    a_wdata_d = a_wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_addr_d  = req_addr;
          a_we_d    = req_we;
          a_word_d  = req_word;
          a_wdata_d = req_wdata;
          rdata_d   = '0;
          err_d     = align_err;
          state_d   = align_err ? RESP : LO;
        end
      end
      LO: begin
        if (!a_we_q) begin
          rdata_d[DW-1:0] = dm_ReadD;
        end
        state_d = a_word_q ? HI : RESP;
      end
      HI: begin
        if (!a_we_q) begin
          rdata_d[2*DW-1:DW] = dm_ReadD;
        end
        state_d = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are computed for the state being entered so they can be registered glitch-free.
  always_comb begin
    dm_address_d  = '0;
    dm_WriteD_d   = '0;
    dm_MemRead_d  = 1'b0;
    dm_MemWrite_d = 1'b0;
    case (state_d)
      LO: begin
        dm_address_d  = a_addr_d;
        dm_WriteD_d   = a_we_d ? a_wdata_d[DW-1:0] : '0;
        dm_MemWrite_d = a_we_d;
        dm_MemRead_d  = ~a_we_d;
      end
      HI: begin
        dm_address_d  = a_addr_d + AW'(1);
        dm_WriteD_d   = a_we_d ? a_wdata_d[2*DW-1:DW] : '0;
        dm_MemWrite_d = a_we_d;
        dm_MemRead_d  = ~a_we_d;
      end
      default: begin
        dm_address_d  = '0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_rdata_d = (state_d == RESP) ? rdata_d : rsp_rdata_q;
    rsp_err_d   = (state_d == RESP) ? err_d : rsp_err_q;
  end

  // Single state register with registered outputs; reset aborts any access and drops the strobes at once.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      a_addr_q      <= '0;
      a_we_q        <= 1'b0;
      a_word_q      <= 1'b0;
      a_wdata_q     <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      dm_address_q  <= '0;
      dm_WriteD_q   <= '0;
      dm_MemRead_q  <= 1'b0;
      dm_MemWrite_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_addr_q      <= a_addr_d;
      a_we_q        <= a_we_d;
      a_word_q      <= a_word_d;
      a_wdata_q     <= a_wdata_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      dm_address_q  <= dm_address_d;
      dm_WriteD_q   <= dm_WriteD_d;
      dm_MemRead_q  <= dm_MemRead_d;
      dm_MemWrite_q <= dm_MemWrite_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dm_address  = dm_address_q;
  assign dm_WriteD   = dm_WriteD_q;
  assign dm_MemRead  = dm_MemRead_q;
  assign dm_MemWrite = dm_MemWrite_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - table-driven scoreboard bench for dm_access_ctrl
module tb_dm_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_word;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  dm_address;
  logic [7:0]  dm_WriteD;
  logic        dm_MemRead;
  logic        dm_MemWrite;
  logic [7:0]  dm_ReadD;

  logic [7:0]  mem [256];

  int cyc;
  int n_pass;
  int n_total;
  int mw_tot;
  int mr_tot;

  typedef struct {
    logic        we;
    logic        word;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          mw0;
    int          mr0;
    int          exp_mw;
    int          exp_mr;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[9];

  dm_access_ctrl #(.AW(8), .DW(8)) dut (
    .clk        (clk),
    .Reset      (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_word   (req_word),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dm_address (dm_address),
    .dm_WriteD  (dm_WriteD),
    .dm_MemRead (dm_MemRead),
    .dm_MemWrite(dm_MemWrite),
    .dm_ReadD   (dm_ReadD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_ReadD = dm_MemRead ? mem[dm_address] : 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_MemWrite) mem[dm_address] <= dm_WriteD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Response checker: pops the scoreboard on every rsp_valid pulse.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, e.rdata});
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        chk("latency", cyc - e.acc, e.lat);
        chk("memwrite_cycles", mw_tot - e.mw0, e.exp_mw);
        chk("memread_cycles", mr_tot - e.mr0, e.exp_mr);
      end
    end
    if (dm_MemWrite) mw_tot = mw_tot + 1;
    if (dm_MemRead) mr_tot = mr_tot + 1;
  end

  task automatic issue(input logic we, input logic word, input logic [7:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rdata,
                       input logic exp_err, input int lat, input bit push, input bit hold,
                       output int acc, output int ready_low);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_we    = we;
    req_word  = word;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    ready_low = 0;
    guard     = 0;
    while (!req_ready && guard < 50) begin
      ready_low++;
      guard++;
      @(negedge clk);
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    acc = cyc;
    @(posedge clk);
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    e.lat    = lat;
    e.acc    = acc;
    e.mw0    = mw_tot;
    e.mr0    = mr_tot;
    e.exp_mw = (exp_err || !we) ? 0 : (word ? 2 : 1);
    e.exp_mr = (exp_err || we) ? 0 : (word ? 2 : 1);
    if (push) exp_q.push_back(e);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 16'h0000;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int acc1, acc2, rl, rl2;
    logic [7:0] a1;

    cyc = 0; n_pass = 0; n_total = 0; mw_tot = 0; mr_tot = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = '{1'b1, 1'b0, 8'h07, 16'h0016, 16'h0000, 1'b0, 2};
    vecs[1] = '{1'b0, 1'b0, 8'h07, 16'h0000, 16'h0016, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 16'hA55A, 16'h0000, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b1, 8'h10, 16'h0000, 16'hA55A, 1'b0, 3};
    vecs[6] = '{1'b1, 1'b0, 8'h30, 16'hFFC3, 16'h0000, 1'b0, 2};
    vecs[7] = '{1'b0, 1'b1, 8'h30, 16'h0000, 16'h00C3, 1'b0, 3};
`ifdef DMCTRL_ALIGN_CHECK_EN
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, 1'b1, 1};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[8] = '{1'b0, 1'b1, 8'h0F, 16'h0000, 16'h0000, 1'b1, 1};
`else
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, 1'b0, 3};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, 1'b0, 3};
    vecs[8] = '{1'b0, 1'b1, 8'h0F, 16'h0000, 16'h5A00, 1'b0, 3};
`endif

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 16'h00EE;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'h0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'd0);
    chk("reset_dm_bus", {14'h0, dm_address, dm_WriteD, dm_MemRead, dm_MemWrite}, 32'd0);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
    rst = 1'b0;
    @(negedge clk);
    chk("no_write_in_reset", {24'h0, mem[8'h40]}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].we, vecs[i].word, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
            vecs[i].exp_err, vecs[i].lat, 1'b1, 1'b0, acc1, rl);
      if (!vecs[i].exp_err) begin
        chk("lo_address", {24'h0, dm_address}, {24'h0, vecs[i].addr});
        if (vecs[i].we) chk("lo_wdata", {24'h0, dm_WriteD}, {24'h0, vecs[i].wdata[7:0]});
        if (vecs[i].word) begin
          @(negedge clk);
          a1 = vecs[i].addr + 8'd1;
          chk("hi_address", {24'h0, dm_address}, {24'h0, a1});
          if (vecs[i].we) chk("hi_wdata", {24'h0, dm_WriteD}, {24'h0, vecs[i].wdata[15:8]});
        end
      end
      drain();
    end

    chk("mem_10", {24'h0, mem[8'h10]}, 32'h5A);
    chk("mem_11", {24'h0, mem[8'h11]}, 32'hA5);
    chk("mem_31", {24'h0, mem[8'h31]}, 32'h00);
`ifdef DMCTRL_ALIGN_CHECK_EN
    chk("mem_ff", {24'h0, mem[8'hFF]}, 32'h00);
    chk("mem_00", {24'h0, mem[8'h00]}, 32'h00);
`else
    chk("mem_ff", {24'h0, mem[8'hFF]}, 32'h34);
    chk("mem_00", {24'h0, mem[8'h00]}, 32'h12);
`endif

    // Back-to-back: valid held high, second request swapped in while the first is in flight.
    issue(1'b0, 1'b0, 8'h10, 16'h0000, 16'h005A, 1'b0, 2, 1'b1, 1'b1, acc1, rl);
    issue(1'b0, 1'b1, 8'h10, 16'h0000, 16'hA55A, 1'b0, 3, 1'b1, 1'b0, acc2, rl2);
    chk("b2b_ready_low", rl2, 32'd2);
    chk("b2b_accept_gap", acc2 - acc1, 32'd3);
    drain();

    // Reset during the high byte of a word store.
    issue(1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 1'b0, 3, 1'b0, 1'b0, acc1, rl);
    @(negedge clk);
    chk("abort_hi_address", {24'h0, dm_address}, 32'h21);
    chk("abort_hi_write", {31'h0, dm_MemWrite}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_strobe_drop", {30'h0, dm_MemWrite, dm_MemRead}, 32'd0);
    chk("abort_ready", {31'h0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_mem_20", {24'h0, mem[8'h20]}, 32'hEF);
    chk("abort_mem_21", {24'h0, mem[8'h21]}, 32'h00);

    issue(1'b0, 1'b1, 8'h20, 16'h0000, 16'h00EF, 1'b0, 3, 1'b1, 1'b0, acc1, rl);
    drain();
    repeat (3) @(negedge clk);
    chk("rsp_rdata_hold", {16'h0, rsp_rdata}, 32'h00EF);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
